// File: rtl/med_dose_scheduler.sv
// Multi-slot medication dose scheduler.
// A prescaled tick drives per-slot countdowns. An expiring slot raises its
// due flag. A round-robin FSM alarms one due slot at a time, waits for the
// patient acknowledge, then hands a timestamped record to the log memory
// over a valid/ready handshake.
module med_dose_scheduler #(
    parameter int SLOTS      = 8,
    parameter int TICK_DIV   = 4,
    parameter int INTERVAL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     cfg_we,
    input  logic [$clog2(SLOTS)-1:0] cfg_slot,
    input  logic [INTERVAL_W-1:0]    cfg_interval,
    input  logic                     ack,
    output logic                     alarm,
    output logic [$clog2(SLOTS)-1:0] alarm_slot,
    output logic [SLOTS-1:0]         due_mask,
    output logic [7:0]               miss_cnt,
    output logic                     log_valid,
    output logic [$clog2(SLOTS)-1:0] log_slot,
    output logic [INTERVAL_W-1:0]    log_time,
    input  logic                     log_ready
);

    localparam int SW = $clog2(SLOTS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALARM = 2'd1;
    localparam logic [1:0] ST_LOG   = 2'd2;

    logic [PW-1:0]         presc_q, presc_d;
    logic [INTERVAL_W-1:0] ts_q, ts_d;
    logic [INTERVAL_W-1:0] interval_q  [SLOTS];
    logic [INTERVAL_W-1:0] interval_d  [SLOTS];
    logic [INTERVAL_W-1:0] countdown_q [SLOTS];
    logic [INTERVAL_W-1:0] countdown_d [SLOTS];
    logic [SLOTS-1:0]      due_q, due_d;
    logic [7:0]            miss_cnt_q, miss_cnt_d;
    logic [1:0]            state_q, state_d;
    logic                  alarm_q, alarm_d;
    logic [SW-1:0]         alarm_slot_q, alarm_slot_d;
    logic                  log_valid_q, log_valid_d;
    logic [SW-1:0]         log_slot_q, log_slot_d;
    logic [INTERVAL_W-1:0] log_time_q, log_time_d;
    logic [SW-1:0]         last_served_q, last_served_d;

    logic                  tick;
    logic                  ack_fire;
    logic                  any_miss;
    logic                  sel_found;
    logic [SW-1:0]         sel_slot;
    logic [SW-1:0]         idx;

    // Prescaler and free-running timestamp, both frozen while ena is low.
    always_comb begin
        tick    = ena && (presc_q == PRE_MAX);
        presc_d = presc_q;
        if (ena) begin
            presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
        end
        ts_d = tick ? ts_q + 1'b1 : ts_q;
    end

    // Per-slot interval/countdown/due update; cfg write wins over a same-cycle
    // tick, and an expiry wins over the ack clear so a new dose stays pending.
    always_comb begin
        ack_fire    = (state_q == ST_ALARM) && ack;
        interval_d  = interval_q;
        countdown_d = countdown_q;
        due_d       = due_q;
        any_miss    = 1'b0;
        if (ack_fire) begin
            due_d[alarm_slot_q] = 1'b0;
        end
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (cfg_we && (cfg_slot == SW'(s))) begin
                interval_d[s]  = cfg_interval;
                countdown_d[s] = cfg_interval;
                if (cfg_interval == '0) begin
                    due_d[s] = 1'b0;
                end
            end else if (tick && (interval_q[s] != '0)) begin
                if (countdown_q[s] == INTERVAL_W'(1)) begin
                    if (due_q[s] && !(ack_fire && (alarm_slot_q == SW'(s)))) begin
                        any_miss = 1'b1;
                    end
                    due_d[s]       = 1'b1;
                    countdown_d[s] = interval_q[s];
                end else begin
                    countdown_d[s] = countdown_q[s] - 1'b1;
                end
            end
        end
        miss_cnt_d = (any_miss && (miss_cnt_q != 8'hFF)) ? miss_cnt_q + 8'd1 : miss_cnt_q;
    end

    // Round-robin pick of the next due slot and the alarm/log FSM.
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= SLOTS; i++) begin
            idx = last_served_q + SW'(i);
            if (!sel_found && due_q[idx]) begin
                sel_found = 1'b1;
                sel_slot  = idx;
            end
        end

        state_d       = state_q;
        alarm_d       = alarm_q;
        alarm_slot_d  = alarm_slot_q;
        log_valid_d   = log_valid_q;
        log_slot_d    = log_slot_q;
        log_time_d    = log_time_q;
        last_served_d = last_served_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d      = ST_ALARM;
                    alarm_d      = 1'b1;
                    alarm_slot_d = sel_slot;
                end
            end
            ST_ALARM: begin
                if (ack) begin
                    state_d     = ST_LOG;
                    alarm_d     = 1'b0;
                    log_valid_d = 1'b1;
                    log_slot_d  = alarm_slot_q;
                    log_time_d  = ts_q;
                end
            end
            ST_LOG: begin
                if (log_ready) begin
                    state_d       = ST_IDLE;
                    log_valid_d   = 1'b0;
                    last_served_d = log_slot_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            ts_q          <= '0;
            due_q         <= '0;
            miss_cnt_q    <= '0;
            state_q       <= ST_IDLE;
            alarm_q       <= 1'b0;
            alarm_slot_q  <= '0;
            log_valid_q   <= 1'b0;
            log_slot_q    <= '0;
            log_time_q    <= '0;
            last_served_q <= '1;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                interval_q[s]  <= '0;
                countdown_q[s] <= '0;
            end
        end else begin
            presc_q       <= presc_d;
            ts_q          <= ts_d;
            due_q         <= due_d;
            miss_cnt_q    <= miss_cnt_d;
            state_q       <= state_d;
            alarm_q       <= alarm_d;
            alarm_slot_q  <= alarm_slot_d;
            log_valid_q   <= log_valid_d;
            log_slot_q    <= log_slot_d;
            log_time_q    <= log_time_d;
            last_served_q <= last_served_d;
            interval_q    <= interval_d;
            countdown_q   <= countdown_d;
        end
    end

    assign alarm      = alarm_q;
    assign alarm_slot = alarm_slot_q;
    assign due_mask   = due_q;
    assign miss_cnt   = miss_cnt_q;
    assign log_valid  = log_valid_q;
    assign log_slot   = log_slot_q;
    assign log_time   = log_time_q;

endmodule

// File: tb/tb_med_dose_scheduler.sv
// Bench for med_dose_scheduler: directed scenarios with fixed expected
// values plus a randomized run checked against a behavioural model.
module tb_med_dose_scheduler;

    localparam int SLOTS    = 8;
    localparam int TICK_DIV = 4;
    localparam int IW       = 8;
    localparam int SW       = 3;
    localparam int VW       = SLOTS + 8 + 1 + SW + 1 + SW + IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_slot = '0;
    logic [IW-1:0] cfg_interval = '0;
    logic          ack = 1'b0;
    logic          alarm;
    logic [SW-1:0] alarm_slot;
    logic [SLOTS-1:0] due_mask;
    logic [7:0]    miss_cnt;
    logic          log_valid;
    logic [SW-1:0] log_slot;
    logic [IW-1:0] log_time;
    logic          log_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    med_dose_scheduler #(.SLOTS(SLOTS), .TICK_DIV(TICK_DIV), .INTERVAL_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
        .cfg_interval(cfg_interval), .ack(ack), .alarm(alarm), .alarm_slot(alarm_slot),
        .due_mask(due_mask), .miss_cnt(miss_cnt), .log_valid(log_valid),
        .log_slot(log_slot), .log_time(log_time), .log_ready(log_ready)
    );

    always #5 clk = ~clk;

    // Behavioural reference model, evaluated from the spec rules each edge.
    int m_pre, m_ts, m_miss, m_aslot, m_lslot, m_ltime, m_last;
    int m_intv [SLOTS];
    int m_cd   [SLOTS];
    logic [SLOTS-1:0] m_due;
    bit m_alarm, m_logv;

    always @(posedge clk) begin : model
        bit tick, ackf, any_miss, found;
        logic [SLOTS-1:0] nd;
        int c;
        if (!rst_n) begin
            m_pre = 0; m_ts = 0; m_miss = 0; m_aslot = 0; m_lslot = 0; m_ltime = 0;
            m_last = SLOTS - 1; m_due = '0; m_alarm = 0; m_logv = 0;
            for (int s = 0; s < SLOTS; s++) begin m_intv[s] = 0; m_cd[s] = 0; end
        end else begin
            tick = ena && (m_pre == TICK_DIV - 1);
            ackf = m_alarm && ack;
            nd = m_due;
            any_miss = 0;
            if (ackf) nd[m_aslot] = 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                if (cfg_we && int'(cfg_slot) == s) begin
                    m_intv[s] = int'(cfg_interval);
                    m_cd[s] = int'(cfg_interval);
                    if (cfg_interval == 0) nd[s] = 1'b0;
                end else if (tick && m_intv[s] != 0) begin
                    if (m_cd[s] == 1) begin
                        if (m_due[s] && !(ackf && m_aslot == s)) any_miss = 1;
                        nd[s] = 1'b1;
                        m_cd[s] = m_intv[s];
                    end else begin
                        m_cd[s] = m_cd[s] - 1;
                    end
                end
            end
            if (m_alarm) begin
                if (ack) begin
                    m_alarm = 0; m_logv = 1; m_lslot = m_aslot; m_ltime = m_ts;
                end
            end else if (m_logv) begin
                if (log_ready) begin m_logv = 0; m_last = m_lslot; end
            end else if (m_due != 0) begin
                found = 0;
                for (int k = 1; k <= SLOTS; k++) begin
                    c = (m_last + k) % SLOTS;
                    if (!found && m_due[c]) begin found = 1; m_aslot = c; m_alarm = 1; end
                end
            end
            m_due = nd;
            if (any_miss && m_miss < 255) m_miss = m_miss + 1;
            if (ena) m_pre = (m_pre == TICK_DIV - 1) ? 0 : m_pre + 1;
            if (tick) m_ts = (m_ts + 1) % (1 << IW);
        end
    end

    // Apply one reset edge; returns at the negedge of cycle 0 after reset.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; ack = 1'b0; log_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] got;
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1;
        @(negedge clk);
        got = {due_mask, miss_cnt, alarm, alarm_slot, log_valid, log_slot, log_time};
        checks++;
        if (got !== '0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", got);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_slot();
        do_reset();
        log_ready = 1'b1;
        cfg_we = 1'b1; cfg_slot = 3'd0; cfg_interval = 8'd3;
        @(negedge clk); cfg_we = 1'b0;              // cycle 1
        repeat (10) @(negedge clk);                 // cycle 11
        checks++;
        if (due_mask !== 8'h00) begin errors++; $display("FAIL due_before_tick11: got %h expected 00", due_mask); end
        @(negedge clk);                             // cycle 12
        checks++;
        if (due_mask !== 8'h01 || alarm !== 1'b0) begin
            errors++; $display("FAIL due_after_tick11: due %h alarm %b expected 01 0", due_mask, alarm);
        end
        @(negedge clk);                             // cycle 13
        checks++;
        if (alarm !== 1'b1 || alarm_slot !== 3'd0) begin
            errors++; $display("FAIL first_alarm: alarm %b slot %0d expected 1 0", alarm, alarm_slot);
        end
        ack = 1'b1;
        @(negedge clk); ack = 1'b0;                 // cycle 14
        checks++;
        if (log_valid !== 1'b1 || log_slot !== 3'd0 || log_time !== 8'd3 || alarm !== 1'b0 || due_mask !== 8'h00) begin
            errors++; $display("FAIL first_log: valid %b slot %0d time %0d alarm %b due %h expected 1 0 3 0 00",
                               log_valid, log_slot, log_time, alarm, due_mask);
        end
        @(negedge clk);                             // cycle 15
        checks++;
        if (log_valid !== 1'b0) begin errors++; $display("FAIL log_one_cycle: valid %b expected 0", log_valid); end
        repeat (9) @(negedge clk);                  // cycle 24
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL no_early_realarm: alarm %b expected 0", alarm); end
        @(negedge clk);                             // cycle 25
        checks++;
        if (alarm !== 1'b1 || alarm_slot !== 3'd0) begin
            errors++; $display("FAIL realarm: alarm %b slot %0d expected 1 0", alarm, alarm_slot);
        end
        ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        checks++;
        if (log_valid !== 1'b1 || log_slot !== 3'd0 || log_time !== 8'd6) begin
            errors++; $display("FAIL second_log: valid %b slot %0d time %0d expected 1 0 6", log_valid, log_slot, log_time);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{1, 2, 5, 1, 2, 5};
        do_reset();
        log_ready = 1'b1;
        cfg_we = 1'b1; cfg_slot = 3'd1; cfg_interval = 8'd2;
        @(negedge clk); cfg_slot = 3'd2;
        @(negedge clk); cfg_slot = 3'd5;
        @(negedge clk); cfg_we = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 40 && alarm !== 1'b1; n++) @(negedge clk);
            checks++;
            if (alarm !== 1'b1 || alarm_slot !== SW'(exp_order[r])) begin
                errors++; $display("FAIL rr_alarm[%0d]: alarm %b slot %0d expected 1 %0d", r, alarm, alarm_slot, exp_order[r]);
            end
            ack = 1'b1;
            @(negedge clk); ack = 1'b0;
            checks++;
            if (log_valid !== 1'b1 || log_slot !== SW'(exp_order[r]) || log_time !== IW'(m_ltime)) begin
                errors++; $display("FAIL rr_log[%0d]: valid %b slot %0d time %0d expected 1 %0d %0d",
                                   r, log_valid, log_slot, log_time, exp_order[r], m_ltime);
            end
        end
        checks++;
        if (miss_cnt !== 8'(m_miss)) begin errors++; $display("FAIL rr_miss: got %0d expected %0d", miss_cnt, m_miss); end
    endtask

    task automatic test_miss();
        do_reset();
        cfg_we = 1'b1; cfg_slot = 3'd3; cfg_interval = 8'd1;
        @(negedge clk); cfg_we = 1'b0;              // cycle 1
        repeat (7) @(negedge clk);                  // cycle 8
        checks++;
        if (miss_cnt !== 8'd1) begin errors++; $display("FAIL miss_after_tick2: got %0d expected 1", miss_cnt); end
        repeat (4) @(negedge clk);                  // cycle 12
        checks++;
        if (miss_cnt !== 8'd2 || alarm !== 1'b1 || alarm_slot !== 3'd3) begin
            errors++; $display("FAIL miss_after_tick3: miss %0d alarm %b slot %0d expected 2 1 3", miss_cnt, alarm, alarm_slot);
        end
        repeat (1040) @(negedge clk);
        checks++;
        if (miss_cnt !== 8'd255 || alarm !== 1'b1 || alarm_slot !== 3'd3) begin
            errors++; $display("FAIL miss_saturate: miss %0d alarm %b slot %0d expected 255 1 3", miss_cnt, alarm, alarm_slot);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cfg_we = 1'b1; cfg_slot = 3'd2; cfg_interval = 8'd1;
        @(negedge clk); cfg_slot = 3'd6;
        @(negedge clk); cfg_we = 1'b0;
        for (int n = 0; n < 40 && alarm !== 1'b1; n++) @(negedge clk);
        checks++;
        if (alarm !== 1'b1 || alarm_slot !== 3'd2) begin
            errors++; $display("FAIL bp_alarm: alarm %b slot %0d expected 1 2", alarm, alarm_slot);
        end
        ack = 1'b1;
        @(negedge clk);
        checks++;
        if (log_valid !== 1'b1 || log_slot !== 3'd2 || log_time !== 8'd1) begin
            errors++; $display("FAIL bp_log: valid %b slot %0d time %0d expected 1 2 1", log_valid, log_slot, log_time);
        end
        for (int n = 0; n < 10; n++) begin
            ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (log_valid !== 1'b1 || log_slot !== 3'd2 || log_time !== 8'd1 || alarm !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: valid %b slot %0d time %0d alarm %b expected 1 2 1 0",
                                   n, log_valid, log_slot, log_time, alarm);
            end
        end
        ack = 1'b0; log_ready = 1'b1;
        @(negedge clk); log_ready = 1'b0;
        checks++;
        if (log_valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid %b expected 0", log_valid); end
        @(negedge clk);
        checks++;
        if (alarm !== 1'b1 || alarm_slot !== 3'd6) begin
            errors++; $display("FAIL bp_next_alarm: alarm %b slot %0d expected 1 6", alarm, alarm_slot);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] got;
        do_reset();
        cfg_we = 1'b1; cfg_slot = 3'd0; cfg_interval = 8'd1;
        @(negedge clk); cfg_we = 1'b0;
        for (int n = 0; n < 40 && alarm !== 1'b1; n++) @(negedge clk);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL mid_alarm: alarm %b expected 1", alarm); end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        got = {due_mask, miss_cnt, alarm, alarm_slot, log_valid, log_slot, log_time};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL mid_reset_clear: got %h expected 0", got); end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            checks++;
            if (alarm !== 1'b0 || due_mask !== 8'h00 || log_valid !== 1'b0) begin
                errors++; $display("FAIL mid_reset_quiet[%0d]: alarm %b due %h valid %b expected 0 00 0", n, alarm, due_mask, log_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got, exp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ena          = ($urandom_range(0, 9) < 8);
            cfg_we       = ($urandom_range(0, 19) == 0);
            cfg_slot     = SW'($urandom_range(0, SLOTS - 1));
            cfg_interval = IW'($urandom_range(0, 5));
            ack          = ($urandom_range(0, 1) == 1);
            log_ready    = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            got = {due_mask, miss_cnt, alarm, alarm_slot, log_valid, log_slot, log_time};
            exp = {m_due, m_miss[7:0], m_alarm, m_aslot[SW-1:0], m_logv, m_lslot[SW-1:0], m_ltime[IW-1:0]};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", n, got, exp);
            end
        end
        cfg_we = 1'b0; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_slot();
        test_round_robin();
        test_miss();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/med_dose_scheduler.md
Name: med_dose_scheduler

Overview:
Multi-slot medication dose scheduler for the factory-test tile. Each slot holds a dose interval in ticks. A prescaled tick drives per-slot countdowns, and slots raise due flags when their countdown expires. A round-robin FSM picks one due slot at a time, raises an alarm, waits for a patient acknowledge, then emits a timestamped log record over a valid/ready handshake to the downstream log memory.

Parameters:
SLOTS, 8, number of dose slots (power of 2, 2..16)
TICK_DIV, 4, clk cycles per tick (>=1)
INTERVAL_W, 8, width of interval, countdown and timestamp

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
ena  input  1  tick enable; when low the prescaler freezes, so timestamp and countdowns freeze too
cfg_we  input  1  write strobe for slot interval
cfg_slot  input  log2(SLOTS)  slot index for cfg write
cfg_interval  input  INTERVAL_W  new interval; 0 = slot disabled
ack  input  1  dose-taken acknowledge
alarm  output  1  a dose alarm is pending
alarm_slot  output  log2(SLOTS)  slot being alarmed
due_mask  output  SLOTS  per-slot due flags
miss_cnt  output  8  saturating count of ticks on which a dose was missed
log_valid  output  1  log record valid
log_slot  output  log2(SLOTS)  slot of log record
log_time  output  INTERVAL_W  timestamp of log record
log_ready  input  1  downstream accepts log record

Behaviour:
- Reset (rst_n low at a clk edge) clears all state: intervals 0, countdowns 0, due_mask 0, timestamp 0, prescaler 0, miss_cnt 0, alarm 0, alarm_slot 0, log_valid 0, log_slot 0, log_time 0, FSM in IDLE, last_served = SLOTS-1. Reset mid-operation aborts any alarm or log with no record.
- Prescaler counts 0..TICK_DIV-1 while ena=1. The tick pulse is high in the cycle where prescaler = TICK_DIV-1. With TICK_DIV=1, tick is high every ena cycle.
- On tick, timestamp increments by 1 and wraps 2^INTERVAL_W-1 -> 0.
- On tick, for each slot with interval != 0:
  - countdown == 1: set due bit and reload countdown = interval.
  - otherwise: countdown decrements.
  - Disabled slots do nothing.
- Miss: on a tick where any slot expires while its due bit is already set, miss_cnt increments by exactly 1 per tick. It saturates at 255.
- Config write: cfg_we sets interval[cfg_slot] = cfg_interval and countdown = cfg_interval.
  - cfg_interval = 0 also clears that slot's due bit.
  - cfg beats a same-cycle tick for that slot: no decrement and no due set.
  - An in-flight alarm or log is unaffected by cfg.
- FSM states and transitions:
  - IDLE: if due_mask != 0, select the first due slot searching from last_served+1 upward, modulo SLOTS. Capture it as alarm_slot and go to ALARM. alarm goes high the cycle after the due bit is visible.
  - ALARM: alarm=1. ack=1 clears due[alarm_slot], loads log_slot = alarm_slot and log_time = timestamp (current value, same cycle), drops alarm, sets log_valid=1, and goes to LOG.
  - LOG: log_valid held with stable slot and time until log_valid && log_ready. On that cycle: log_valid=0, last_served = log_slot, go to IDLE. Earliest next alarm is the following cycle.
- ack is ignored in IDLE and LOG.
- Ack clearing slot k while slot k expires on the same tick: due bit ends set (new dose pending), and no miss is counted.
- due_mask is the registered flag vector, reflecting updates 1 cycle after their cause.

Test Plan:
- TICK_DIV=4, ena=1, write slot0 interval 3 in the first cycle after reset. Ticks occur at cycles 3, 7, 11 after reset. due_mask[0]=1 after the cycle-11 tick. alarm=1 with alarm_slot=0 the next cycle.
- Continuing the above, ack with log_ready=1 -> log_valid for 1 cycle with log_slot=0, log_time=3. due_mask[0]=0. FSM returns to IDLE, and alarm recurs 3 ticks later with log_time=6 on ack.
- Slots 1, 2 and 5 with interval 2 written in the same early window so they expire together. Acking each -> alarms in order 1, 2, 5. Next round after re-expiry starts search at 6 and serves 1, 2, 5 again.
- Slot3 interval 1, never ack -> alarm_slot=3 held. miss_cnt=2 after the 3rd tick, and it saturates at 255 after 256+ ticks.
- log_ready=0 after ack -> log_valid, log_slot and log_time stable for 10 cycles. Further ack pulses have no effect and no new alarm starts despite other due slots. log_ready=1 -> handshake completes and the next alarm appears 1 cycle later.
- rst_n low for 1 cycle while alarm=1 -> next cycle every output is 0 and due_mask=0. No alarm ever recurs without a new cfg write.
